// File: rtl/uart_tx_arbiter_pkg.sv
// Shared configuration for the UART transmit arbiter: FSM encoding, byte width,
// UART register map and the timeout counter sizing helper.
package uart_tx_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_SENDING = 2'd2
  } state_t;

  // Register-port UART wrapper address map (byte offsets).
  localparam logic [3:0] UART_REG_TXDATA = 4'h0;
  localparam logic [3:0] UART_REG_RXDATA = 4'h4;
  localparam logic [3:0] UART_REG_STATUS = 4'h8;
  localparam logic [3:0] UART_REG_BAUD   = 4'hC;

  // Bits needed to hold 0..timeout without wrapping.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus the UART transmit-side signals, bundled so the
// arbiter sits between the register wrapper and the uart instance.
interface uart_tx_arbiter_if;
  import uart_tx_arbiter_pkg::*;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [DATA_W-1:0] uart_txdata;
  logic              uart_txbegin;
  logic              uart_txbusy;

  // master: requesters and UART; slave: the arbiter itself.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, uart_txbusy,
    input  req0_ready, req1_ready, uart_txdata, uart_txbegin
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, uart_txbusy,
    output req0_ready, req1_ready, uart_txdata, uart_txbegin
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a UART transmitter: captures one
// byte, raises txbegin until the UART reports busy, then waits for the frame end.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int START_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic            grant,
  output logic            busy,
  output logic            err,
  input  logic            err_clr
);

  localparam int                CNT_W     = cnt_width(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] txdata;
  logic [DATA_W-1:0] txdata_nxt;
  logic              txbegin;
  logic              txbegin_nxt;
  logic [1:0]        ready;
  logic [1:0]        ready_nxt;
  logic              grant_nxt;
  logic              last;
  logic              last_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pick;
  logic              timeout;

  // On a tie the requester that was not served last wins; otherwise whoever asks.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_served);
    return (v0 && v1) ? ~last_served : v1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      txdata  <= '0;
      txbegin <= 1'b0;
      ready   <= 2'b00;
      grant   <= 1'b0;
      last    <= 1'b1;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      txdata  <= txdata_nxt;
      txbegin <= txbegin_nxt;
      ready   <= ready_nxt;
      grant   <= grant_nxt;
      last    <= last_nxt;
      err     <= err_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    txdata_nxt  = txdata;
    txbegin_nxt = txbegin;
    ready_nxt   = 2'b00;
    grant_nxt   = grant;
    last_nxt    = last;
    cnt_nxt     = cnt;
    pick        = 1'b0;
    timeout     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!bus.uart_txbusy && (bus.req0_valid || bus.req1_valid)) begin
          pick        = rr_pick(bus.req0_valid, bus.req1_valid, last);
          txdata_nxt  = pick ? bus.req1_data : bus.req0_data;
          grant_nxt   = pick;
          txbegin_nxt = 1'b1;
          ready_nxt   = pick ? 2'b10 : 2'b01;
          cnt_nxt     = '0;
          state_nxt   = ST_START;
        end
      end

      ST_START: begin
        if (bus.uart_txbusy) begin
          txbegin_nxt = 1'b0;
          state_nxt   = ST_SENDING;
        end else if (cnt >= CNT_LIMIT) begin
          // UART never acknowledged: drop the byte but still rotate priority.
          timeout     = 1'b1;
          txbegin_nxt = 1'b0;
          last_nxt    = grant;
          state_nxt   = ST_IDLE;
        end else begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
      end

      ST_SENDING: begin
        if (!bus.uart_txbusy) begin
          last_nxt  = grant;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        txbegin_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    err_nxt = timeout ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  assign busy             = (state != ST_IDLE);
  assign bus.uart_txdata  = txdata;
  assign bus.uart_txbegin = txbegin;
  assign bus.req0_ready   = ready[0];
  assign bus.req1_ready   = ready[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reset values, directed handshake and timeout
// sequences, a vector table of single transfers, and randomized queue traffic.
module tb_uart_tx_arbiter;

  logic clk;
  logic rst_n;
  logic grant;
  logic busy;
  logic err;
  logic err_clr;
  logic uart_auto;
  logic auto_busy;
  logic man_busy;

  int vectors;
  int miscompares;

  uart_tx_arbiter_if bus();

  assign bus.uart_txbusy = uart_auto ? auto_busy : man_busy;

  uart_tx_arbiter #(.START_TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .grant   (grant),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic       idx;
    logic [7:0] data;
  } cap_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  // UART model: acknowledges txbegin after 1..3 cycles, stays busy 1..6 cycles.
  initial begin
    int unsigned rise;
    int unsigned hold;
    auto_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_auto && bus.uart_txbegin && !auto_busy) begin
        rise = $urandom_range(1, 3);
        hold = $urandom_range(1, 6);
        repeat (rise - 1) @(negedge clk);
        auto_busy = 1'b1;
        repeat (hold) @(negedge clk);
        auto_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] c0 [$];
    logic [7:0] c1 [$];
    cap_t       exp_q [$];
    cap_t       e;
    logic       rr_last;
    logic       idx;
    logic       got;
    int         cyc;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    err_clr     = 1'b0;
    uart_auto   = 1'b0;
    man_busy    = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;

    tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
    tbl[5] = '{1'b1, 1'b0, 8'h5E, 8'h00, 1'b0, 8'h5E};
    tbl[6] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 8'h44};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h77, 1'b1, 8'h77};
    tbl[8] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b0, 8'h99};

    // Reset values
    #3;
    check("rst_txbegin", bus.uart_txbegin, 1'b0);
    check("rst_txdata", bus.uart_txdata, 8'h00);
    check("rst_ready0", bus.req0_ready, 1'b0);
    check("rst_ready1", bus.req1_ready, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request with a hand-driven UART busy
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    tick();
    check("single_ready0", bus.req0_ready, 1'b1);
    check("single_ready1", bus.req1_ready, 1'b0);
    check("single_txdata", bus.uart_txdata, 8'hA5);
    check("single_txbegin", bus.uart_txbegin, 1'b1);
    check("single_busy", busy, 1'b1);
    bus.req0_valid = 1'b0;
    tick();
    check("single_ready_once", bus.req0_ready, 1'b0);
    check("single_txbegin_hold", bus.uart_txbegin, 1'b1);
    man_busy = 1'b1;
    tick();
    check("single_txbegin_drop", bus.uart_txbegin, 1'b0);
    check("single_sending", busy, 1'b1);
    repeat (9) tick();
    check("single_still_busy", busy, 1'b1);
    man_busy = 1'b0;
    tick();
    check("single_idle", busy, 1'b0);
    check("single_grant", grant, 1'b0);

    // Vector table with the auto UART, starting from a fresh tie pointer
    pulse_reset();
    uart_auto = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req0_valid = tbl[i].v0;
      bus.req0_data  = tbl[i].d0;
      bus.req1_valid = tbl[i].v1;
      bus.req1_data  = tbl[i].d1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        got = bus.req0_ready || bus.req1_ready;
      end
      check($sformatf("tbl%0d_captured", i), got, 1'b1);
      check($sformatf("tbl%0d_ready0", i), bus.req0_ready, !tbl[i].exp_grant);
      check($sformatf("tbl%0d_ready1", i), bus.req1_ready, tbl[i].exp_grant);
      check($sformatf("tbl%0d_txdata", i), bus.uart_txdata, tbl[i].exp_data);
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].exp_grant);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      check($sformatf("tbl%0d_ready_off", i), {bus.req1_ready, bus.req0_ready}, 2'b00);
      wait_idle($sformatf("tbl%0d_idle", i), 60);
      check($sformatf("tbl%0d_txbegin_off", i), bus.uart_txbegin, 1'b0);
    end
    repeat (10) @(negedge clk);
    uart_auto = 1'b0;

    // Busy gate: external busy holds off the request
    @(negedge clk);
    man_busy       = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("gate_hold%0d", k), {bus.req1_ready, bus.uart_txbegin}, 2'b00);
    end
    man_busy = 1'b0;
    tick();
    check("gate_ready1", bus.req1_ready, 1'b1);
    check("gate_txdata", bus.uart_txdata, 8'h5A);
    check("gate_grant", grant, 1'b1);
    bus.req1_valid = 1'b0;
    man_busy = 1'b1;
    tick();
    man_busy = 1'b0;
    tick();
    wait_idle("gate_idle", 10);

    // START timeout, then clear, then timeout coinciding with clear
    check("to_err_before", err, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hC3;
    tick();
    check("to_ready0", bus.req0_ready, 1'b1);
    bus.req0_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("to_start%0d", k), {bus.uart_txbegin, err}, 2'b10);
    end
    tick();
    check("to_txbegin", bus.uart_txbegin, 1'b0);
    check("to_err", err, 1'b1);
    check("to_idle", busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", err, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hE1;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hE2;
    tick();
    check("to2_tie_grant", grant, 1'b1);
    check("to2_txdata", bus.uart_txdata, 8'hE2);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to2_set_wins", err, 1'b1);
    check("to2_txbegin", bus.uart_txbegin, 1'b0);
    tick();
    check("to2_err_sticky", err, 1'b1);

    // Reset in the middle of SENDING
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h4B;
    tick();
    check("rs_grant1", grant, 1'b1);
    bus.req1_valid = 1'b0;
    man_busy = 1'b1;
    repeat (3) tick();
    check("rs_sending", {busy, bus.uart_txbegin}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_txbegin", bus.uart_txbegin, 1'b0);
    check("rs_txdata", bus.uart_txdata, 8'h00);
    check("rs_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rs_grant", grant, 1'b0);
    check("rs_busy", busy, 1'b0);
    check("rs_err", err, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    man_busy = 1'b0;
    check("rs_no_repulse", {bus.req1_ready, bus.req0_ready}, 2'b00);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h22;
    tick();
    check("rs_tie_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
    check("rs_tie_grant", grant, 1'b0);
    check("rs_tie_data", bus.uart_txdata, 8'h11);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    man_busy = 1'b1;
    tick();
    man_busy = 1'b0;
    tick();
    wait_idle("rs_idle", 10);

    // Randomized traffic: two byte queues merged round-robin by the model
    pulse_reset();
    uart_auto = 1'b1;
    rr_last   = 1'b1;
    for (int r = 0; r < 6; r++) begin
      q0.delete();
      q1.delete();
      exp_q.delete();
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) q0.push_back(8'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) q1.push_back(8'($urandom));
      c0 = q0;
      c1 = q1;
      while (c0.size() > 0 || c1.size() > 0) begin
        if (c0.size() > 0 && (c1.size() == 0 || rr_last == 1'b1)) begin
          exp_q.push_back('{1'b0, c0.pop_front()});
          rr_last = 1'b0;
        end else begin
          exp_q.push_back('{1'b1, c1.pop_front()});
          rr_last = 1'b1;
        end
      end
      @(negedge clk);
      bus.req0_valid = (q0.size() > 0);
      bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      bus.req1_valid = (q1.size() > 0);
      bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy) && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (bus.req0_ready && bus.req1_ready)
          check($sformatf("rnd%0d_ready_excl", r), 2'b11, 2'b01);
        if (bus.req0_ready || bus.req1_ready) begin
          idx = bus.req1_ready;
          if (exp_q.size() == 0) begin
            check($sformatf("rnd%0d_extra_capture", r), 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_idx", r), idx, e.idx);
            check($sformatf("rnd%0d_data", r), bus.uart_txdata, e.data);
            check($sformatf("rnd%0d_grant", r), grant, e.idx);
          end
          if (idx) begin
            if (q1.size() > 0) void'(q1.pop_front());
          end else begin
            if (q0.size() > 0) void'(q0.pop_front());
          end
        end
        bus.req0_valid = (q0.size() > 0);
        bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req1_valid = (q1.size() > 0);
        bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      end
      check($sformatf("rnd%0d_in_budget", r), (cyc < 2000), 1'b1);
      check($sformatf("rnd%0d_all_sent", r), exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter START_TIMEOUT, default 255, SHALL be the maximum cycles to wait in START for uart_txbusy to rise.
REQ-003 clk  in  1  system clock; every register updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req0_valid  in  1  requester 0 (CPU register path) has a byte to send.
REQ-006 req0_data  in  8  requester 0 byte; held stable while req0_valid=1.
REQ-007 req0_ready  out  1  one-cycle pulse: requester 0 byte captured.
REQ-008 req1_valid, req1_data, req1_ready  in/in/out  1/8/1  same as REQ-005..007, for requester 1 (boot/debug path).
REQ-009 uart_txdata  out  8  byte presented to the UART transmitter.
REQ-010 uart_txbegin  out  1  transmit start request to the UART.
REQ-011 uart_txbusy  in  1  UART transmitter busy.
REQ-012 grant  out  1  index of the requester owning the current or last byte.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 err  out  1  sticky START-timeout flag.
REQ-015 err_clr  in  1  clears err.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, START and SENDING.
REQ-017 In IDLE, with uart_txbusy=0 and at least one valid sampled high, the block SHALL at the next edge latch the chosen requester's data into uart_txdata, set grant, set uart_txbegin=1, pulse that requester's ready for exactly one cycle, and enter START.
REQ-018 In IDLE, with uart_txbusy=1, the block SHALL grant nothing.
REQ-019 Arbitration SHALL be round-robin: when both valids are high, the requester not served last wins.
REQ-020 After reset, the "last served" pointer SHALL equal 1, so requester 0 wins the first tie.
REQ-021 In START, uart_txbegin and uart_txdata SHALL hold until uart_txbusy is sampled 1; the block SHALL then clear uart_txbegin at the next edge and enter SENDING.
REQ-022 In START, if uart_txbusy is still 0 after START_TIMEOUT cycles, the block SHALL clear uart_txbegin, set err=1 and return to IDLE; the last-served pointer SHALL still update.
REQ-023 In SENDING, the block SHALL return to IDLE at the first edge where uart_txbusy=0 and update the last-served pointer to grant.
REQ-024 Valid inputs SHALL be ignored outside IDLE.
REQ-025 A requester SHALL deassert valid (or present new data) no later than one cycle after its ready pulse; minimum IDLE-to-IDLE time is 3 cycles, so no byte is captured twice.
REQ-026 If err_clr and a timeout occur in the same cycle, err SHALL end at 1 (set wins).
REQ-027 The START timeout counter SHALL be ceil(log2(START_TIMEOUT+1)) bits wide, cleared on START entry, and SHALL saturate without wrapping.
REQ-028 Ready outputs SHALL be registered, and the two ready outputs SHALL never both be 1.

Reset
REQ-029 With rst_n=0, the block SHALL immediately force state=IDLE, uart_txbegin=0, uart_txdata=8'h00, req0_ready=0, req1_ready=0, grant=0, busy=0, err=0, the last-served pointer to 1 and the timeout counter to 0.
REQ-030 Reset asserted mid-START or mid-SENDING SHALL abandon the byte with no ready re-pulse; the UART's own frame completion is outside this block's control.

Structure
REQ-031 The state encoding (IDLE=2'd0, START=2'd1, SENDING=2'd2) SHALL live in the shared config include, alongside the UART register addresses.
REQ-032 The block SHALL be a single module with no sub-modules; the round-robin choice SHALL be a combinational function inside it.
REQ-033 The block SHALL sit between the register-port UART wrapper and the uart instance, driving its txdata/txbegin and reading txbusy.

Verification
REQ-034 Single request: req0_valid=1, data=8'hA5, UART model raises txbusy 2 cycles after txbegin and holds it 10 cycles -> req0_ready pulses once, uart_txdata=8'hA5, txbegin drops the cycle after txbusy is seen, IDLE is re-entered, grant=0.
REQ-035 Tie after reset: both valids high, data 8'h11/8'h22 -> order on uart_txdata is 8'h11 then 8'h22, then 8'h11 again if both stay valid with new pulses.
REQ-036 Busy gate: uart_txbusy=1 externally while req1_valid=1 -> no ready and no txbegin until txbusy falls; the byte is then captured within 1 cycle.
REQ-037 Timeout: UART model never raises txbusy, START_TIMEOUT=4 -> txbegin falls after 4 START cycles, err=1; err_clr pulse -> err=0; simultaneous timeout and err_clr -> err=1.
REQ-038 Reset mid-SENDING: rst_n low for 1 cycle during SENDING -> all outputs at reset values asynchronously, and the next request is accepted normally with grant=0 on a tie.
